// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the memory-stage SRAM controller
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  localparam int unsigned BASE_ADDR_DEF = 1024;
  localparam int HALF_W = 16;
endpackage

// File: rtl/sram_phase_counter.sv
// sram_phase_counter: loadable down-counter timing one SRAM halfword phase
module sram_phase_counter #(
  parameter int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  output logic [W-1:0] cnt,
  output logic         tc
);
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= W'(N - 1);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign tc = cnt == '0;
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: splits 32-bit loads/stores into two 16-bit async SRAM accesses
module mem_stage_sram_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR     = BASE_ADDR_DEF,
  parameter int          ADDR_W        = 18,
  parameter int          ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [HALF_W-1:0] sram_dq_out,
  input  logic [HALF_W-1:0] sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              sram_oe_n
);
  localparam int CW = $clog2(ACCESS_CYCLES);
  state_t state, state_n;
  logic is_wr, req, load, tc, busy, first;
  logic [ADDR_W-2:0] word_q;
  logic [31:0] wd_q, offset;
  logic [CW-1:0] cnt;
  logic unused_offset;
  assign req = wr_en | rd_en;
  assign offset = address - BASE_ADDR;
  assign unused_offset = ^{offset[31:ADDR_W+1], offset[1:0]};
  sram_phase_counter #(.N(ACCESS_CYCLES)) u_cnt (
    .clk (clk),
    .rst (rst),
    .load(load),
    .cnt (cnt),
    .tc  (tc)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr     <= 1'b0;
      word_q    <= '0;
      wd_q      <= '0;
      read_data <= '0;
    end else begin
      if (state == IDLE && req) begin
        is_wr  <= wr_en;
        word_q <= offset[ADDR_W:2];
        wd_q   <= write_data;
      end
      if (!is_wr && tc && state == LO) read_data[15:0] <= sram_dq_in;
      if (!is_wr && tc && state == HI) read_data[31:16] <= sram_dq_in;
    end
  end
  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      IDLE: if (req) begin state_n = LO; load = 1'b1; end
      LO:   if (tc) begin state_n = HI; load = 1'b1; end
      HI:   if (tc) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // first cycle of each phase leaves we_n high so the address settles before the strobe
  assign busy        = state == LO || state == HI;
  assign first       = cnt == CW'(ACCESS_CYCLES - 1);
  assign ready       = state == DONE || (state == IDLE && !req);
  assign sram_addr   = {word_q, state == HI};
  assign sram_dq_out = state == HI ? wd_q[31:16] : wd_q[15:0];
  assign sram_dq_oe  = busy && is_wr;
  assign sram_we_n   = !(busy && is_wr && !first);
  assign sram_oe_n   = !(busy && !is_wr);
endmodule
